// File: rtl/uart_rx_fifo_if.sv
// Local-bus side of the UART receiver: FIFO read port and sticky error flags.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          err_clr;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_valid, fifo_count, frame_err, parity_err, overrun
    );
    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_valid, fifo_count, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampled 8-bit UART receiver (optional even parity) feeding a
// first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int OS_DIV     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic          Clk,
    input  logic          RSTn,
    input  logic          RX,
    uart_rx_fifo_if.slave bus
);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam int            TW        = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t state, state_n;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          rx_s1, rx_s2, rx_prev;
    logic [2:0]    sync_fill;
    logic          fall_edge;
    logic [TW-1:0] tick_cnt;
    logic          os_tick, tick_clr;
    logic [3:0]    s;
    logic          s_clr, smp7, smp8, maj, sample_pt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          shift_en, pe_set, pe_pending, push_req, push_q;
    logic          fe_set, pe_err_set;
    logic          fe_q, pe_q, ovr_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_pop, do_push;

    always_ff @(posedge Clk or negedge RSTn)
        if (!RSTn) rst_sync <= '0;
        else       rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    // sync_fill keeps an edge from being seen until rx_prev holds a real pin
    // value, so a line already low when reset releases is not taken as a start.
    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= '0;
        end else begin
            rx_s1     <= RX;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            sync_fill <= {sync_fill[1:0], 1'b1};
        end
    assign fall_edge = sync_fill[2] & rx_prev & ~rx_s2;

    assign os_tick = (tick_cnt == TICK_LAST);
    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n)                    tick_cnt <= '0;
        else if (tick_clr || os_tick)  tick_cnt <= '0;
        else                           tick_cnt <= tick_cnt + 1'b1;

    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) begin
            s    <= '0;
            smp7 <= 1'b1;
            smp8 <= 1'b1;
        end else begin
            if (s_clr)        s <= '0;
            else if (os_tick) s <= s + 4'd1;
            if (os_tick && s == 4'd7) smp7 <= rx_s2;
            if (os_tick && s == 4'd8) smp8 <= rx_s2;
        end
    assign sample_pt = os_tick && (s == 4'd9);
    assign maj       = (smp7 & smp8) | (smp7 & rx_s2) | (smp8 & rx_s2);

    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n    = state;
        s_clr      = 1'b0;
        tick_clr   = 1'b0;
        shift_en   = 1'b0;
        pe_set     = 1'b0;
        push_req   = 1'b0;
        fe_set     = 1'b0;
        pe_err_set = 1'b0;
        unique case (state)
            IDLE:
                if (fall_edge) begin
                    state_n  = START;
                    s_clr    = 1'b1;
                    tick_clr = 1'b1;
                end
            START:
                if (sample_pt) state_n = maj ? IDLE : DATA;
            DATA:
                if (sample_pt) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
                end
            PARITY:
                if (sample_pt) begin
                    pe_set  = (maj != ^shreg);
                    state_n = STOP;
                end
            STOP:
                if (sample_pt) begin
                    if (!maj) begin
                        fe_set   = 1'b1;
                        s_clr    = 1'b1;
                        tick_clr = 1'b1;
                        state_n  = BRK;
                    end else begin
                        pe_err_set = pe_pending;
                        push_req   = !pe_pending;
                        state_n    = IDLE;
                    end
                end
            BRK:
                // Any low sample restarts the full-bit high qualification.
                if (!rx_s2) begin
                    s_clr    = 1'b1;
                    tick_clr = 1'b1;
                end else if (os_tick && s == 4'd15) begin
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) begin
            shreg      <= '0;
            bit_idx    <= '0;
            pe_pending <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            push_q <= push_req;
            if (state == START) begin
                bit_idx    <= '0;
                pe_pending <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {maj, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (pe_set) pe_pending <= 1'b1;
        end

    assign full    = (count == DEPTH_C);
    assign do_pop  = bus.rd_en && (count != '0);
    assign do_push = push_q && (!full || do_pop);

    always_ff @(posedge Clk)
        if (do_push) mem[wr_ptr] <= shreg;

    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end

    always_ff @(posedge Clk or negedge rst_n)
        if (!rst_n) begin
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (fe_set)           fe_q <= 1'b1;
            else if (bus.err_clr) fe_q <= 1'b0;
            if (pe_err_set)       pe_q <= 1'b1;
            else if (bus.err_clr) pe_q <= 1'b0;
            if (push_q && full && !do_pop) ovr_q <= 1'b1;
            else if (bus.err_clr)          ovr_q <= 1'b0;
        end

    assign bus.rd_data    = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.rx_valid   = (count != '0);
    assign bus.fifo_count = count;
    assign bus.frame_err  = fe_q;
    assign bus.parity_err = pe_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: a queue-based byte/flag model checked
// every cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    logic Clk = 1'b0;
    logic RSTn = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    always #5 Clk = ~Clk;

    uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus0 ();
    uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus1 ();

    uart_rx_fifo #(.OS_DIV(8), .FIFO_DEPTH(16), .PARITY_EN(1'b0)) dut0 (
        .Clk(Clk), .RSTn(RSTn), .RX(rx0), .bus(bus0)
    );
    uart_rx_fifo #(.OS_DIV(8), .FIFO_DEPTH(16), .PARITY_EN(1'b1)) dut1 (
        .Clk(Clk), .RSTn(RSTn), .RX(rx1), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    int bit_clks = 128;
    bit chk_en = 1'b0;
    bit quiet = 1'b0;
    logic [7:0] mq[$];
    bit m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Model acts at the start of the stop bit, ahead of the DUT decision.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)             m_fe = 1'b1;
        else if (mq.size() == 16) m_ovr = 1'b1;
        else                      mq.push_back(b);
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input bit par_en,
                              input logic par_bit, input logic stop_val, input int stop_bits,
                              input bit use_model);
        logic [7:0] d;
        d = b;
        set_rx(which, 1'b0);
        cyc(bit_clks);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            cyc(bit_clks);
        end
        if (par_en) begin
            set_rx(which, par_bit);
            cyc(bit_clks);
        end
        if (use_model) model_frame(d, stop_val);
        set_rx(which, stop_val);
        cyc(bit_clks * stop_bits);
        set_rx(which, 1'b1);
    endtask

    task automatic pop();
        bus0.rd_en = 1'b1;
        cyc(1);
        bus0.rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr_err();
        bus0.err_clr = 1'b1;
        cyc(1);
        bus0.err_clr = 1'b0;
        m_fe = 1'b0;
        m_pe = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic drain();
        while (mq.size() > 0) pop();
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            if (bus0.rx_valid) begin
                if (mq.size() == 0) chk("head_exists", mq.size(), 1);
                else                chk("head", bus0.rd_data, mq[0]);
            end
            if (quiet) begin
                chk("count", bus0.fifo_count, mq.size());
                chk("valid", bus0.rx_valid, (mq.size() != 0) ? 1 : 0);
                chk("frame_err", bus0.frame_err, m_fe);
                chk("parity_err", bus0.parity_err, m_pe);
                chk("overrun", bus0.overrun, m_ovr);
            end
        end
    end

    initial begin
        logic [7:0] rb;
        bit bad;
        bus0.rd_en = 1'b0; bus0.err_clr = 1'b0;
        bus1.rd_en = 1'b0; bus1.err_clr = 1'b0;

        cyc(3);
        chk("rst_rd_data", bus0.rd_data, 0);
        chk("rst_valid", bus0.rx_valid, 0);
        chk("rst_count", bus0.fifo_count, 0);
        chk("rst_fe", bus0.frame_err, 0);
        chk("rst_pe", bus0.parity_err, 0);
        chk("rst_ovr", bus0.overrun, 0);
        RSTn = 1'b1;
        cyc(10);
        chk_en = 1'b1;
        quiet = 1'b1;

        quiet = 1'b0;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1, 1);
        cyc(20);
        quiet = 1'b1;
        chk("a5_valid", bus0.rx_valid, 1);
        chk("a5_data", bus0.rd_data, 8'hA5);
        chk("a5_count", bus0.fifo_count, 1);
        pop();
        chk("a5_pop_valid", bus0.rx_valid, 0);
        chk("a5_pop_count", bus0.fifo_count, 0);

        rx0 = 1'b0;
        cyc(60);
        rx0 = 1'b1;
        cyc(200);
        chk("glitch_count", bus0.fifo_count, 0);
        chk("glitch_fe", bus0.frame_err, 0);

        quiet = 1'b0;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 2, 1);
        cyc(300);
        quiet = 1'b1;
        chk("brk_fe", bus0.frame_err, 1);
        chk("brk_count", bus0.fifo_count, 0);
        quiet = 1'b0;
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, 1, 1);
        cyc(20);
        quiet = 1'b1;
        chk("after_brk_data", bus0.rd_data, 8'h55);
        pop();
        clr_err();
        chk("fe_cleared", bus0.frame_err, 0);

        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 1, 0);
        cyc(20);
        chk("par_bad_pe", bus1.parity_err, 1);
        chk("par_bad_count", bus1.fifo_count, 0);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1, 0);
        cyc(20);
        chk("par_ok_count", bus1.fifo_count, 1);
        chk("par_ok_data", bus1.rd_data, 8'h07);
        chk("par_ok_fe", bus1.frame_err, 0);

        quiet = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 0, 1'b0, 1'b1, 1, 1);
        cyc(20);
        quiet = 1'b1;
        chk("full_count", bus0.fifo_count, 16);
        chk("full_ovr", bus0.overrun, 1);
        for (int i = 0; i < 16; i++) begin
            chk("full_order", bus0.rd_data, i);
            pop();
        end
        chk("full_drained", bus0.rx_valid, 0);
        clr_err();
        chk("ovr_cleared", bus0.overrun, 0);

        for (int k = 0; k < 2; k++) begin
            bit_clks = (k == 0) ? 124 : 132;
            quiet = 1'b0;
            for (int i = 0; i < 6; i++) send_frame(0, 8'($urandom), 0, 1'b0, 1'b1, 1, 1);
            cyc(20);
            quiet = 1'b1;
            chk("baud_count", bus0.fifo_count, 6);
            drain();
        end

        for (int it = 0; it < 14; it++) begin
            bit_clks = 124 + 4 * int'($urandom_range(0, 2));
            rb = 8'($urandom);
            bad = ($urandom_range(0, 6) == 0);
            quiet = 1'b0;
            send_frame(0, rb, 0, 1'b0, bad ? 1'b0 : 1'b1, bad ? 2 : 1, 1);
            if (bad || $urandom_range(0, 2) == 0) begin
                cyc(bad ? 300 : 20);
                quiet = 1'b1;
                repeat ($urandom_range(0, 3)) pop();
                if ($urandom_range(0, 3) == 0) clr_err();
            end
        end
        cyc(20);
        quiet = 1'b1;
        drain();
        clr_err();

        bit_clks = 128;
        quiet = 1'b0;
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1, 1);
        cyc(20);
        quiet = 1'b1;
        chk("pre_rst_count", bus0.fifo_count, 1);
        quiet = 1'b0;
        rx0 = 1'b0;
        cyc(128 + 64);
        chk_en = 1'b0;
        RSTn = 1'b0;
        #2;
        mq.delete();
        m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0;
        chk("mid_rst_rd_data", bus0.rd_data, 0);
        chk("mid_rst_valid", bus0.rx_valid, 0);
        chk("mid_rst_count", bus0.fifo_count, 0);
        chk("mid_rst_fe", bus0.frame_err, 0);
        cyc(3);
        RSTn = 1'b1;
        chk_en = 1'b1;
        quiet = 1'b1;
        cyc(128);
        rx0 = 1'b1;
        cyc(256);
        chk("post_rst_count", bus0.fifo_count, 0);
        quiet = 1'b0;
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 1, 1);
        cyc(20);
        quiet = 1'b1;
        chk("post_rst_data", bus0.rd_data, 8'hC3);
        chk("post_rst_count1", bus0.fifo_count, 1);
        pop();
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8-bit asynchronous serial receiver, 16x oversampled, with a first-word-fall-through receive FIFO.
- Receive-side counterpart of the system UART transmit line.
- Runs in the Clk_14_7456MHz domain; frames arrive on the RX pin, bytes are read by the local bus/CPU side.
- Frame: 1 start, 8 data LSB-first, optional even parity, 1 stop.

Parameters:
- OS_DIV, 8, clocks per oversample tick (14.7456 MHz / (16 × 115200) = 8); legal range ≥ 1.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥ 2.
- PARITY_EN, 0, 1 = expect an even-parity bit between data and stop.

Ports:
- Clk  input  1  receive clock (14.7456 MHz).
- RSTn  input  1  asynchronous active-low reset.
- RX  input  1  serial input, idle high, asynchronous to Clk.
- rd_en  input  1  pop FIFO head; ignored when empty.
- err_clr  input  1  clear sticky error flags.
- rd_data  output  8  FIFO head byte, valid while rx_valid = 1.
- rx_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
- frame_err  output  1  sticky: stop bit sampled low.
- parity_err  output  1  sticky: parity mismatch (PARITY_EN = 1 only).
- overrun  output  1  sticky: byte completed while FIFO full.

Behaviour:
- Reset (async assert, sync deassert by Clk):
  - rd_data = 8'h00; rx_valid, frame_err, parity_err, overrun = 0; fifo_count = 0.
  - Synchronizer flops = 1; state = IDLE; tick and sample counters = 0.
- RX passes through a 2-FF synchronizer before any use; 2-clock input latency.
- Tick generator: free-running counter 0..OS_DIV-1; os_tick pulses for one clock at wrap.
- Sample counter s (0..15) advances on os_tick; bit value = majority of samples at s = 7, 8, 9.
- FSM:
  - IDLE: synced RX 1→0 edge → START; clear s and tick counter on that clock.
  - START: at s = 9, majority 0 → DATA, bit index 0; majority 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: at each s = 9 shift the majority bit into the shift register, LSB first. After bit 7 → PARITY if PARITY_EN, else STOP.
  - PARITY: at s = 9 compare the majority bit to the XOR of the data bits; on mismatch flag pe_pending. → STOP.
  - STOP, at s = 9:
    - majority 1 and no pe_pending: push the byte. → IDLE.
    - majority 1 with pe_pending: set parity_err, discard the byte. → IDLE.
    - majority 0: set frame_err, discard the byte, → BRK.
  - BRK: wait for synced RX = 1 for at least one full bit (16 ticks) → IDLE. Prevents a break from generating spurious frames.
- Push timing: FIFO write occurs on the clock after the stop-bit decision; rx_valid/fifo_count update one clock later.
- FIFO:
  - First-word-fall-through; rd_data always reflects the head.
  - Pop on rd_en & rx_valid; next entry appears on the following clock.
  - Push when full without a same-cycle pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle when full: both execute, fifo_count unchanged, no overrun.
  - Push and pop when empty: push only.
  - Read/write pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
- Error flags: sticky until err_clr. If err_clr coincides with a new error event, set wins.
- Reset mid-frame: the partial frame is discarded. After release the FSM resumes in IDLE and resynchronizes only on the next 1→0 edge; a low RX at release is not treated as a start.

Test Plan:
- Single frame 8'hA5 at 115200 (128 clocks/bit), OS_DIV = 8, PARITY_EN = 0 → rx_valid high, rd_data = 8'hA5, fifo_count = 1; rd_en pulse → rx_valid 0, count 0.
- 60-clock low glitch on idle RX → state returns to IDLE, no push, no error flags.
- Frame 8'h3C with stop bit held low for 2 bit times, then idle → frame_err = 1, FIFO empty; next frame 8'h55 received correctly; err_clr → frame_err = 0.
- PARITY_EN = 1: frame 8'h07 with parity bit 0 (wrong) → parity_err = 1, nothing pushed; correct parity 1 → 8'h07 pushed.
- Send 17 bytes 8'h00..8'h10 without reading (depth 16) → fifo_count = 16, overrun = 1; reads return 8'h00..8'h0F in order.
- Back-to-back frames with receiver baud ±3% off nominal → all bytes correct. Assert RSTn low mid-data-bit → all outputs at reset values; the following complete frame 8'hC3 is received correctly.
